// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and helpers for the peripheral bus interconnect
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  function automatic int field_width(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - address field to one-hot slave match, lowest index wins
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter logic [N_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_CODES = '0
) (
  input  logic [SEL_MSB-SEL_LSB:0] field,
  output logic [N_SLAVES-1:0]      match,
  output logic                     hit
);

  localparam int SW = field_width(SEL_MSB, SEL_LSB);

  // The first matching code claims the select; later duplicates are masked by hit.
  always_comb begin
    match = '0;
    hit   = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && (field == SLAVE_CODES[i*SW +: SW])) begin
        match[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect_mux.sv
// rtl/bus_interconnect_mux.sv - single-master, N-slave bus interconnect with wait states,
// unmapped-address error and per-transaction timeout
module bus_interconnect_mux
  import bus_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter logic [N_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_CODES = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [WIDTH-1:0]          addr,
  input  logic                      we,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      ack,
  output logic                      err,
  output logic [WIDTH-1:0]          rdata,
  output logic [N_SLAVES-1:0]       s_req,
  output logic [WIDTH-1:0]          s_addr,
  output logic                      s_we,
  output logic [WIDTH-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]       s_ack,
  input  logic [N_SLAVES*WIDTH-1:0] s_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t              state;
  logic [N_SLAVES-1:0] sel_q;
  logic [CW-1:0]       cnt;
  logic [N_SLAVES-1:0] dec_match;
  logic                dec_hit;
  logic                slave_ack;
  logic [WIDTH-1:0]    rd_mux;

  bus_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .SEL_MSB    (SEL_MSB),
    .SEL_LSB    (SEL_LSB),
    .SLAVE_CODES(SLAVE_CODES)
  ) u_dec (
    .field(addr[SEL_MSB:SEL_LSB]),
    .match(dec_match),
    .hit  (dec_hit)
  );

  // Acks from slaves other than the selected one are masked out here.
  assign slave_ack = |(s_ack & sel_q);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | s_rdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      s_req   <= '0;
      s_addr  <= '0;
      s_we    <= 1'b0;
      s_wdata <= '0;
      sel_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          if (req) begin
            s_addr  <= addr;
            s_we    <= we;
            s_wdata <= wdata;
            if (dec_hit) begin
              sel_q <= dec_match;
              s_req <= dec_match;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              ack   <= 1'b1;
              err   <= 1'b1;
              state <= RESP;
            end
          end
        end
        BUSY: begin
          if (slave_ack) begin
            s_req <= '0;
            ack   <= 1'b1;
            err   <= 1'b0;
            rdata <= s_we ? '0 : rd_mux;
            state <= RESP;
          end else if (cnt == CNT_MAX) begin
            s_req <= '0;
            ack   <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect_mux.sv
// tb/tb_bus_interconnect_mux.sv - scoreboard bench for bus_interconnect_mux
module tb_bus_interconnect_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic [W-1:0]   addr = '0;
  logic           we = 1'b0;
  logic [W-1:0]   wdata = '0;
  logic           ack, err;
  logic [W-1:0]   rdata;
  logic [N-1:0]   s_req;
  logic [W-1:0]   s_addr;
  logic           s_we;
  logic [W-1:0]   s_wdata;
  logic [N-1:0]   s_ack;
  logic [N*W-1:0] s_rdata;

  logic [N-1:0]   resp_ack = '0;
  logic [N-1:0]   noise_ack = '0;
  logic [W-1:0]   sd [N];
  int             ws [N];
  bit             mute [N];
  int             wcnt [N];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         e;
    logic [W-1:0] d;
    int           due;
  } exp_t;
  exp_t exp_q[$];

  assign s_ack   = resp_ack | noise_ack;
  assign s_rdata = {sd[3], sd[2], sd[1], sd[0]};

  bus_interconnect_mux dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .s_req  (s_req),
    .s_addr (s_addr),
    .s_we   (s_we),
    .s_wdata(s_wdata),
    .s_ack  (s_ack),
    .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Slave model: ack after ws[i] wait cycles of its own s_req, unless muted.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_req[i] && !resp_ack[i]) begin
        if (!mute[i] && wcnt[i] >= ws[i]) resp_ack[i] = 1'b1;
        else wcnt[i]++;
      end else begin
        resp_ack[i] = 1'b0;
        if (!s_req[i]) wcnt[i] = 0;
      end
    end
  end

  // Scoreboard: every ack must match the oldest expected response, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("err", err, x.e);
          chk("rdata", rdata, x.d);
          chk("ack_cycle", cyc, x.due);
        end
      end else begin
        chk("idle_err_rdata", {err, rdata}, 0);
      end
    end
  end

  // Called at a negedge; the next posedge samples req. s_req must equal e_sreq in
  // cycles s_from..s_to and be 0 in the other cycles up to the ack.
  task automatic txn(input logic [W-1:0] a, input bit w, input logic [W-1:0] wd,
                     input bit e_err, input logic [W-1:0] e_rd, input int lat,
                     input logic [N-1:0] e_sreq, input int s_from, input int s_to,
                     input bit hold);
    bit got;
    exp_t x;
    got   = 1'b0;
    addr  = a;
    we    = w;
    wdata = wd;
    req   = 1'b1;
    x.e = e_err; x.d = e_rd; x.due = cyc + lat;
    exp_q.push_back(x);
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      if (k <= lat) chk("s_req", s_req, (k >= s_from && k <= s_to) ? e_sreq : '0);
      if (k >= s_from && k <= s_to) begin
        chk("s_addr", s_addr, a);
        chk("s_we", s_we, w);
        chk("s_wdata", s_wdata, wd);
      end
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_seen", 0, 1);
    if (!hold) req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      sd[i] = 32'h0; ws[i] = 0; mute[i] = 1'b0; wcnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ack, err, rdata, s_req, s_we}, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read, slave 2, zero wait
    sd[2] = 32'hDEAD_BEEF;
    txn(32'h2000_0010, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 4'b0100, 1, 1, 1'b0);
    @(negedge clk);

    // Write, slave 1, three wait states
    sd[1] = 32'h5555_AAAA; ws[1] = 3;
    txn(32'h1000_0004, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 5, 4'b0010, 1, 4, 1'b0);
    @(negedge clk);

    // Unmapped
    txn(32'hF000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 1, 0, 1'b0);
    @(negedge clk);

    // Timeout on slave 3 with other slaves chattering
    mute[3] = 1'b1; noise_ack = 4'b0111;
    txn(32'h3000_0008, 1'b0, 32'h0, 1'b1, 32'h0, 17, 4'b1000, 1, 16, 1'b0);
    mute[3] = 1'b0; noise_ack = '0;
    @(negedge clk);

    // Reset during BUSY of a wait-stated read
    ws[0] = 5; sd[0] = 32'h0BAD_F00D;
    addr = 32'h0000_0040; we = 1'b0; req = 1'b1;
    @(negedge clk);
    chk("rst_busy_s_req_before", s_req, 4'b0001);
    @(posedge clk);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_s_req", s_req, 0);
    chk("rst_busy_ack", ack, 0);
    chk("rst_busy_state", dut.state, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_ack", ack, 0);
    rst_n = 1'b1;
    @(negedge clk);
    ws[0] = 0; sd[0] = 32'hC0FF_EE00;
    txn(32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'hC0FF_EE00, 2, 4'b0001, 1, 1, 1'b0);
    @(negedge clk);

    // Back-to-back reads, req held, unselected acks toggling
    sd[0] = 32'hA0A0_A0A0; sd[3] = 32'h3333_1111; sd[1] = 32'hFFFF_FFFF; sd[2] = 32'hEEEE_EEEE;
    noise_ack = 4'b0110;
    txn(32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'hA0A0_A0A0, 2, 4'b0001, 1, 1, 1'b1);
    txn(32'h3000_0200, 1'b0, 32'h0, 1'b0, 32'h3333_1111, 3, 4'b1000, 2, 2, 1'b0);
    noise_ack = '0;

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_interconnect_mux.md
Name: bus_interconnect_mux

Overview:
- Parametrised single-master, N-slave bus interconnect for the rysyCore peripheral bus. Successor of the fixed RAM/GPIO write-enable splitter.
- Decodes a configurable address field against per-slave codes and forwards one registered request at a time to the selected slave.
- Waits for a slave acknowledge, then returns read data with an error flag.
- Adds wait-state support, an unmapped-address error and a per-transaction timeout.

Parameters:
- WIDTH, 32, address/data width.
- N_SLAVES, 4, number of slave ports (1..16).
- SEL_MSB, 31, upper bit of the decode field in addr.
- SEL_LSB, 28, lower bit of the decode field (field width SW = SEL_MSB-SEL_LSB+1).
- SLAVE_CODES, {4'd3,4'd2,4'd1,4'd0}, packed N_SLAVES*SW; slice i is the decode code of slave i.
- TIMEOUT, 16, cycles in BUSY without ack before an error response (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  master request; held with addr/we/wdata until ack.
- addr  in  WIDTH  master address.
- we  in  1  1 = write, 0 = read.
- wdata  in  WIDTH  master write data.
- ack  out  1  one-cycle response strobe to master.
- err  out  1  valid with ack; 1 = unmapped or timeout.
- rdata  out  WIDTH  read data, valid with ack.
- s_req  out  N_SLAVES  one-hot slave request.
- s_addr  out  WIDTH  latched address, broadcast to all slaves.
- s_we  out  1  latched write enable, broadcast.
- s_wdata  out  WIDTH  latched write data, broadcast.
- s_ack  in  N_SLAVES  per-slave acknowledge.
- s_rdata  in  N_SLAVES*WIDTH  per-slave read data; slice i belongs to slave i.

Behaviour:
- Reset (async, rst_n=0): state IDLE. ack, err, rdata, s_req, s_addr, s_we, s_wdata, the select register and the timeout counter all 0.
- Decode: slave i matches when addr[SEL_MSB:SEL_LSB] == SLAVE_CODES slice i. If several codes match, the lowest index wins. No match = unmapped.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On req=1, latch addr/we/wdata into s_addr/s_we/s_wdata.
  - Mapped address: latch one-hot select, clear counter, go BUSY.
  - Unmapped address: set err_q=1, rdata_q=0, go RESP. No s_req is issued.
- BUSY:
  - s_req = select (registered, one-hot); s_* outputs stay stable.
  - If s_ack[sel]=1: capture rdata_q = s_rdata[sel] (0 for writes), err_q=0, go RESP. Deassert s_req on the next edge.
  - Else increment counter. When the counter reaches TIMEOUT-1 with no ack, set err_q=1, rdata_q=0, go RESP.
  - s_ack bits of unselected slaves are ignored.
- RESP: ack=1 for exactly one cycle with err/rdata from the _q registers, then go IDLE. req is not sampled in RESP.
- Latency: req sampled at edge 0 -> s_req high in cycle 1 -> a slave acking in cycle 1 gives ack in cycle 2. Each slave wait state adds one cycle. Unmapped gives ack in cycle 1. Timeout gives ack TIMEOUT+1 cycles after the req edge.
- Throughput: at most one transaction per 3 cycles (mapped) or 2 (unmapped). A back-to-back req is accepted in the IDLE cycle after RESP.
- ack, err and rdata are 0 whenever state != RESP.
- Outstanding limit is 1. A master that drops req while BUSY does not cancel the transaction; the response is still produced.
- Reset asserted mid-transaction: immediate return to IDLE with s_req=0. No ack is produced.
- Write transactions follow the same flow; rdata=0 on their ack.

Decomposition:
- Package bus_pkg: state enum (IDLE, BUSY, RESP) and a function returning the decode field width from SEL_MSB/SEL_LSB.
- One sub-module, bus_addr_decoder: combinational, addr field -> one-hot match plus hit flag, with priority encode. Instantiated once. The FSM, counter and datapath registers stay in the top.

Test Plan:
- Read, slave 2 zero-wait: addr=0x2000_0010, s_rdata[2]=0xDEAD_BEEF, s_ack[2] high in cycle 1 -> s_req=4'b0100 in cycle 1; ack=1, err=0, rdata=0xDEAD_BEEF in cycle 2.
- Write, slave 1 with 3 wait states: addr=0x1000_0004, wdata=0x1234_5678 -> s_we=1, s_wdata stable for 4 cycles, ack in cycle 5, rdata=0.
- Unmapped: addr=0xF000_0000 -> s_req never asserted; ack=1, err=1 in cycle 1.
- Timeout: slave 3 never acks, TIMEOUT=16 -> ack=1, err=1 in cycle 17; s_req low from cycle 17.
- Reset mid-BUSY: rst_n low during cycle 2 of a wait-stated read -> s_req=0 and state IDLE immediately; no ack. After release, a new read completes normally.
- Back-to-back reads to slaves 0 then 3 with req held continuously -> acks in cycles 2 and 5, each with the correct slave's data. Unselected s_ack pulses have no effect.
